// File: rtl/generic_sram_byte_en_req_bridge.sv
// Request/response bridge onto a single-cycle byte-enabled SRAM client port.
// Requests pass straight through to the SRAM pins. Read data returns one
// cycle after sram_read_en and is captured in a small response FIFO. Reads
// are only accepted while a FIFO slot is guaranteed, so a stalled consumer
// can never cause read data to be lost or overwritten.
module generic_sram_byte_en_req_bridge #(
   parameter int NUM_ADDR_BITS = 32,
   parameter int NUM_DATA_BITS = 32,
   parameter int RSP_DEPTH     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [NUM_ADDR_BITS-1:0]   req_addr,
   input  logic [NUM_DATA_BITS-1:0]   req_wdata,
   input  logic [NUM_DATA_BITS/8-1:0] req_byte_en,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [NUM_DATA_BITS-1:0]   rsp_rdata,
   output logic [NUM_ADDR_BITS-1:0]   sram_addr,
   output logic [NUM_DATA_BITS-1:0]   sram_write_data,
   output logic                       sram_write_en,
   output logic [NUM_DATA_BITS/8-1:0] sram_byte_en,
   output logic                       sram_read_en,
   input  logic [NUM_DATA_BITS-1:0]   sram_read_data
);

   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);

   logic [NUM_DATA_BITS-1:0] fifo_q [RSP_DEPTH];
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   logic                     inflight_q, inflight_d;

   logic can_read;
   logic accept;
   logic push;
   logic pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Credit uses registered occupancy only; a same-cycle pop never frees a
   // slot, which keeps req_ready independent of rsp_ready.
   assign can_read  = ({1'b0, count_q} + (CW+1)'(inflight_q)) < (CW+1)'(RSP_DEPTH);
   assign req_ready = !rst && (req_write || can_read);
   assign accept    = req_valid && req_ready;

   assign sram_addr       = req_addr;
   assign sram_write_data = req_wdata;
   assign sram_byte_en    = req_byte_en;
   assign sram_write_en   = accept && req_write;
   assign sram_read_en    = accept && !req_write;

   assign push      = inflight_q;
   assign rsp_valid = (count_q != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_rdata = fifo_q[rd_ptr_q];

   // Next-state for pointers, occupancy and the read-in-flight flag.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      inflight_d = sram_read_en;
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control registers; reset drops any read still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
      end
   end

   // Response storage, cleared on reset so rsp_rdata reads as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
      end else if (push) begin
         fifo_q[wr_ptr_q] <= sram_read_data;
      end
   end

   // Overflow would mean the credit check is broken.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && (count_q == CW'(RSP_DEPTH))));

   // The two SRAM strobes are mutually exclusive.
   a_excl_en: assert property (@(posedge clk) !(sram_write_en && sram_read_en));

endmodule

// File: tb/tb_generic_sram_byte_en_req_bridge.sv
module tb_generic_sram_byte_en_req_bridge;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst1;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_byte_en;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [31:0] sram_addr, sram_write_data, sram_read_data;
   logic        sram_write_en, sram_read_en;
   logic [3:0]  sram_byte_en;

   logic        d1_req_valid, d1_req_ready, d1_rsp_valid, d1_rsp_ready;
   logic [31:0] d1_req_addr, d1_rsp_rdata, d1_sram_addr, d1_sram_wdata, d1_sram_rdata;
   logic        d1_sram_we, d1_sram_re;
   logic [3:0]  d1_sram_be;

   generic_sram_byte_en_req_bridge #(.NUM_ADDR_BITS(32), .NUM_DATA_BITS(32), .RSP_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .sram_addr(sram_addr), .sram_write_data(sram_write_data), .sram_write_en(sram_write_en),
      .sram_byte_en(sram_byte_en), .sram_read_en(sram_read_en), .sram_read_data(sram_read_data));

   generic_sram_byte_en_req_bridge #(.NUM_ADDR_BITS(32), .NUM_DATA_BITS(32), .RSP_DEPTH(1)) dut1 (
      .clk(clk), .rst(rst1),
      .req_valid(d1_req_valid), .req_ready(d1_req_ready), .req_write(1'b0),
      .req_addr(d1_req_addr), .req_wdata(32'h0), .req_byte_en(4'hF),
      .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_rdata(d1_rsp_rdata),
      .sram_addr(d1_sram_addr), .sram_write_data(d1_sram_wdata), .sram_write_en(d1_sram_we),
      .sram_byte_en(d1_sram_be), .sram_read_en(d1_sram_re), .sram_read_data(d1_sram_rdata));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: byte-lane writes, registered read data one cycle later.
   logic [31:0] sram_mem [256];
   initial for (int i = 0; i < 256; i++) sram_mem[i] = 32'h0;
   always @(posedge clk) begin
      if (sram_write_en)
         for (int b = 0; b < 4; b++)
            if (sram_byte_en[b]) sram_mem[sram_addr[7:0]][8*b +: 8] <= sram_write_data[8*b +: 8];
      if (sram_read_en) sram_read_data <= sram_mem[sram_addr[7:0]];
   end

   always @(posedge clk) if (d1_sram_re) d1_sram_rdata <= d1_sram_addr ^ 32'h5A5A_0000;

   // Reference model state and scoreboard.
   logic [31:0] ref_mem [256];
   typedef struct { logic [31:0] data; int acc; } exp_t;
   exp_t exp_q[$];
   int   pop_cyc[$];
   int   errors = 0;
   int   checks = 0;
   int   last_acc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Monitor: pops expectations whenever a response is consumed.
   logic        prev_hold = 1'b0;
   logic [31:0] prev_data = 32'h0;
   exp_t        e;
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_hold && rsp_valid) chk("rsp_stable", rsp_rdata, prev_data);
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rsp actual=%h expected=none", rsp_rdata);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_data", rsp_rdata, e.data);
               checks++;
               if (cyc - e.acc < 2) begin
                  errors++;
                  $display("FAIL rsp_too_early actual=%0d expected>=2", cyc - e.acc);
               end
               pop_cyc.push_back(cyc);
            end
         end
         prev_hold = rsp_valid && !rsp_ready;
         prev_data = rsp_rdata;
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic acc);
      logic [31:0] m;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_byte_en = be;
      @(negedge clk);
      acc = req_ready;
      if (acc) begin
         chk("wr_en", 32'(sram_write_en), 32'(wr));
         chk("rd_en", 32'(sram_read_en), 32'(!wr));
         last_acc = cyc;
         if (wr) begin
            m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            ref_mem[a[7:0]] = (ref_mem[a[7:0]] & ~m) | (d & m);
         end else begin
            exp_q.push_back('{ref_mem[a[7:0]], cyc});
         end
      end else begin
         chk("en_idle", {30'h0, sram_write_en, sram_read_en}, 32'h0);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while (exp_q.size() > 0 && k < budget) begin @(posedge clk); #1; k++; end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      logic acc;
      int   n_acc, a, t_acc;
      int   acc1[$];
      logic [31:0] q1[$];

      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      rst = 1'b1; rst1 = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 0; req_wdata = 0; req_byte_en = 0;
      rsp_ready = 1'b0;
      d1_req_valid = 1'b0; d1_req_addr = 0; d1_rsp_ready = 1'b1;

      // Reset state, with a read request pending.
      repeat (3) @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_en", {30'h0, sram_write_en, sram_read_en}, 32'h0);
      chk("rst_d1_rsp_valid", 32'(d1_rsp_valid), 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0; rst = 1'b0; rst1 = 1'b0;

      // Full write then read back, latency 2.
      rsp_ready = 1'b1;
      req(1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, acc);
      chk("wr_accept", 32'(acc), 32'h1);
      @(negedge clk);
      chk("we_pulse_end", 32'(sram_write_en), 32'h0);
      @(posedge clk); #1;
      pop_cyc.delete();
      req(1'b0, 32'h10, 32'h0, 4'h0, acc);
      t_acc = last_acc;
      drain(10);
      checks++;
      if (pop_cyc.size() == 0 || pop_cyc[0] - t_acc != 2) begin
         errors++;
         $display("FAIL rd_latency actual=%0d expected=2", pop_cyc.size() ? pop_cyc[0] - t_acc : -1);
      end

      // Partial byte write.
      req(1'b1, 32'h20, 32'h1122_3344, 4'hF, acc);
      req(1'b1, 32'h20, 32'h0000_BB00, 4'b0010, acc);
      req(1'b0, 32'h20, 32'h0, 4'h0, acc);
      drain(10);

      // Back-to-back reads.
      for (int i = 0; i < 8; i++) req(1'b1, 32'(i), 32'(i), 4'hF, acc);
      pop_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         req(1'b0, 32'(i), 32'h0, 4'h0, acc);
         chk("b2b_ready", 32'(acc), 32'h1);
      end
      drain(20);
      chk("b2b_count", 32'(pop_cyc.size()), 32'd8);
      for (int i = 1; i < pop_cyc.size(); i++)
         chk("b2b_consec", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);

      // Consumer stalled: credit limits accepted reads, writes still flow.
      rsp_ready = 1'b0;
      n_acc = 0; a = 0;
      for (int k = 0; k < 10; k++) begin
         req(1'b0, 32'(a), 32'h0, 4'h0, acc);
         if (acc) begin n_acc++; a++; end
      end
      chk("stall_accepts", 32'(n_acc), 32'd4);
      req(1'b1, 32'h80, 32'hDEAD_BEEF, 4'hF, acc);
      chk("write_while_full", 32'(acc), 32'h1);
      rsp_ready = 1'b1;
      drain(20);

      // Randomised traffic with random back-pressure.
      for (int k = 0; k < 300; k++) begin
         rsp_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) idle(1);
         else req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)), acc);
      end
      rsp_ready = 1'b1;
      drain(50);

      // Reset in the middle of operation.
      rsp_ready = 1'b0;
      req(1'b0, 32'h1, 32'h0, 4'h0, acc);
      req(1'b0, 32'h2, 32'h0, 4'h0, acc);
      req(1'b0, 32'h3, 32'h0, 4'h0, acc);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("midrst_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_rsp_rdata", rsp_rdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; rsp_ready = 1'b1;
      req(1'b0, 32'h5, 32'h0, 4'h0, acc);
      chk("post_rst_accept", 32'(acc), 32'h1);
      drain(10);
      idle(5);
      @(negedge clk);
      chk("post_rst_idle", 32'(rsp_valid), 32'h0);
      @(posedge clk); #1;

      // Single-entry FIFO: one read every three cycles.
      for (int k = 0; k < 26; k++) begin
         d1_req_valid = (k < 20);
         @(negedge clk);
         if (d1_rsp_valid) begin
            if (q1.size() == 0) chk("d1_unexpected", d1_rsp_rdata, 32'hFFFF_FFFF);
            else chk("d1_data", d1_rsp_rdata, q1.pop_front());
         end
         if (d1_req_valid && d1_req_ready) begin
            acc1.push_back(cyc);
            q1.push_back(d1_req_addr ^ 32'h5A5A_0000);
         end
         @(posedge clk); #1;
         d1_req_addr = 32'(acc1.size());
      end
      d1_req_valid = 1'b0;
      chk("d1_accepts", 32'(acc1.size()), 32'd7);
      for (int i = 1; i < acc1.size(); i++)
         chk("d1_spacing", 32'(acc1[i] - acc1[i-1]), 32'd3);
      chk("d1_drained", 32'(q1.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/generic_sram_byte_en_req_bridge.md
Name: generic_sram_byte_en_req_bridge

Overview:
Converts a valid/ready request channel and a valid/ready read-response channel into the single-cycle SRAM client signalling of generic_sram_byte_en_if, driving its sram_client side. It sits directly upstream of any byte-enabled SRAM model or macro, and is the standard way for bus masters and DMA engines to reach it. SRAM read latency is fixed at 1 cycle. A credit-checked response FIFO absorbs read data, so response back-pressure never drops or overwrites data.

Parameters:
NUM_ADDR_BITS, 32, address width; matches the interface.
NUM_DATA_BITS, 32, data width; multiple of 8; matches the interface.
RSP_DEPTH, 4, read-response FIFO entries; must be >=1; >=3 sustains 1 read/cycle.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  request accepted this cycle when req_valid&&req_ready
req_write  input  1  1=write, 0=read
req_addr  input  NUM_ADDR_BITS  word address
req_wdata  input  NUM_DATA_BITS  write data
req_byte_en  input  NUM_DATA_BITS/8  byte lane enables
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer takes data
rsp_rdata  output  NUM_DATA_BITS  read data, in request order
sram_addr  output  NUM_ADDR_BITS  to interface addr
sram_write_data  output  NUM_DATA_BITS  to interface write_data
sram_write_en  output  1  to interface write_en
sram_byte_en  output  NUM_DATA_BITS/8  to interface byte_en
sram_read_en  output  1  to interface read_en
sram_read_data  input  NUM_DATA_BITS  from interface read_data; valid the cycle after sram_read_en

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state is cleared on rst.
- State:
  - inflight: 1 bit, set the cycle after a read is issued.
  - fifo: RSP_DEPTH entries, with rd/wr pointers and count 0..RSP_DEPTH.
- Credit check: can_read = (count + inflight) < RSP_DEPTH, using registered values only.
  - A same-cycle pop grants no credit, so req_ready never depends combinationally on rsp_ready.
- Readiness:
  - req_ready = !rst && (req_write || can_read).
  - Writes never stall.
- SRAM drive (combinational, zero latency):
  - sram_addr = req_addr, sram_write_data = req_wdata, sram_byte_en = req_byte_en, always passed through.
  - sram_write_en = req_valid && req_ready && req_write.
  - sram_read_en = req_valid && req_ready && !req_write.
  - Both enables are 0 while rst=1. Both are never 1 together.
- Read pipeline:
  - Read issued at cycle t: inflight=1 during t+1.
  - At the end of t+1, sram_read_data is pushed into the fifo.
  - rsp_valid rises at t+2 (latency 2 from accept to rsp_valid).
- Response channel:
  - rsp_valid = (count != 0); rsp_rdata = fifo[rd_ptr], stable while rsp_valid && !rsp_ready.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo RSP_DEPTH; non-power-of-2 depths are supported.
- Full: the credit check guarantees a push never occurs with count == RSP_DEPTH. An assertion checks this.
- Ordering:
  - A write at t followed by a read of the same address at t+1 returns the new data; the SRAM provides this.
  - A write with byte_en=0 still asserts sram_write_en, with no data change.
- Reset values: req_ready=0 during rst; rsp_valid=0, rsp_rdata=0, sram_write_en=0, sram_read_en=0.
- Reset mid-operation: any in-flight read is discarded and the fifo is emptied. After rst deasserts, the first accept is possible that same cycle.

Test Plan:
- Write addr 0x10 data 0xA5A5A5A5 byte_en 4'hF, then read 0x10 with rsp_ready=1 -> sram_write_en pulse 1 cycle; rsp_valid 2 cycles after read accept; rsp_rdata 0xA5A5A5A5.
- Partial write byte_en 4'b0010 data 0x0000BB00 over 0x11223344, then read -> 0x1122BB44.
- 8 back-to-back reads of addr 0..7 (data=addr), rsp_ready=1, RSP_DEPTH=4 -> req_ready held 1, 8 in-order responses on consecutive cycles.
- rsp_ready=0 with continuous reads -> exactly 4 reads accepted, req_ready=0 afterwards, writes still accepted. Raise rsp_ready -> data 0..3 in order, no loss.
- RSP_DEPTH=1, continuous reads, rsp_ready=1 -> one read accepted every 3 cycles.
- rst asserted the cycle after a read accept with 2 entries queued -> rsp_valid=0 next cycle. No stale response after release.
